// File: rtl/subneg_bcd_display.sv
// rtl/subneg_bcd_display.sv - byte result to multiplexed 4-digit 7-segment display via double-dabble
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   val_in, val_we      result byte and its one-cycle write strobe
//   signed_mode         interpret val_in as two's complement (sampled with val_in)
//   seg, dig_sel        segments {g,f,e,d,c,b,a} and one-hot digit enable (ones,tens,hundreds,sign)
//   busy                conversion in progress
module subneg_bcd_display #(
  parameter int REFRESH_DIV = 1024,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] val_in,
  input  logic       val_we,
  input  logic       signed_mode,
  output logic [6:0] seg,
  output logic [3:0] dig_sel,
  output logic       busy
);

  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  iter_q, iter_d;
  logic [11:0] bcd_q, bcd_d;
  logic [7:0]  mag_q, mag_d;
  logic        sign_q, sign_d;
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  pend_val_q, pend_val_d;
  logic        pend_sm_q, pend_sm_d;
  logic [3:0]  disp_h_q, disp_h_d;
  logic [3:0]  disp_t_q, disp_t_d;
  logic [3:0]  disp_o_q, disp_o_d;
  logic        disp_sign_q, disp_sign_d;
  logic [15:0] refresh_q, refresh_d;
  logic [1:0]  idx_q, idx_d;

  logic        start;
  logic [7:0]  start_val;
  logic        start_sm;
  logic        start_neg;
  logic [7:0]  adj;
  logic [6:0]  seg_raw;
  logic [3:0]  dig_raw;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Only ones and tens need the add-3 step: with an 8-bit input the hundreds
  // nibble is at most 1 before the final shift, so it can never reach 5.
  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    bcd_d        = bcd_q;
    mag_d        = mag_q;
    sign_d       = sign_q;
    pend_valid_d = pend_valid_q;
    pend_val_d   = pend_val_q;
    pend_sm_d    = pend_sm_q;
    disp_h_d     = disp_h_q;
    disp_t_d     = disp_t_q;
    disp_o_d     = disp_o_q;
    disp_sign_d  = disp_sign_q;
    start        = 1'b0;
    start_val    = val_in;
    start_sm     = signed_mode;
    start_neg    = 1'b0;
    adj          = {dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};

    case (state_q)
      IDLE: begin
        if (val_we) start = 1'b1;
      end
      CONV: begin
        if (val_we) begin
          pend_valid_d = 1'b1;
          pend_val_d   = val_in;
          pend_sm_d    = signed_mode;
        end
        bcd_d  = {bcd_q[10:8], adj, mag_q[7]};
        mag_d  = {mag_q[6:0], 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = COMMIT;
      end
      COMMIT: begin
        disp_h_d     = bcd_q[11:8];
        disp_t_d     = bcd_q[7:4];
        disp_o_d     = bcd_q[3:0];
        disp_sign_d  = sign_q;
        pend_valid_d = 1'b0;
        state_d      = IDLE;
        // A fresh strobe on the return-to-idle edge beats the buffered value.
        if (val_we) begin
          start = 1'b1;
        end else if (pend_valid_q) begin
          start     = 1'b1;
          start_val = pend_val_q;
          start_sm  = pend_sm_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      start_neg = start_sm & start_val[7];
      state_d   = CONV;
      iter_d    = 3'd0;
      bcd_d     = 12'd0;
      sign_d    = start_neg;
      // 0x80 negates to 0x80, which read unsigned is the correct 128.
      mag_d     = start_neg ? (~start_val + 8'd1) : start_val;
    end
  end

  always_comb begin
    refresh_d = refresh_q + 16'd1;
    idx_d     = idx_q;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d = 16'd0;
      idx_d     = idx_q + 2'd1;
    end
  end

  always_comb begin
    seg_raw = 7'h00;
    dig_raw = 4'b0001;
    case (idx_q)
      2'd0: begin
        dig_raw = 4'b0001;
        seg_raw = seg_code(disp_o_q);
      end
      2'd1: begin
        dig_raw = 4'b0010;
        seg_raw = (disp_h_q == 4'd0 && disp_t_q == 4'd0) ? 7'h00 : seg_code(disp_t_q);
      end
      2'd2: begin
        dig_raw = 4'b0100;
        seg_raw = (disp_h_q == 4'd0) ? 7'h00 : seg_code(disp_h_q);
      end
      default: begin
        dig_raw = 4'b1000;
        seg_raw = disp_sign_q ? 7'h40 : 7'h00;
      end
    endcase
    seg     = ACTIVE_LOW ? ~seg_raw : seg_raw;
    dig_sel = ACTIVE_LOW ? ~dig_raw : dig_raw;
    busy    = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      iter_q       <= 3'd0;
      bcd_q        <= 12'd0;
      mag_q        <= 8'd0;
      sign_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_val_q   <= 8'd0;
      pend_sm_q    <= 1'b0;
      disp_h_q     <= 4'd0;
      disp_t_q     <= 4'd0;
      disp_o_q     <= 4'd0;
      disp_sign_q  <= 1'b0;
      refresh_q    <= 16'd0;
      idx_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      bcd_q        <= bcd_d;
      mag_q        <= mag_d;
      sign_q       <= sign_d;
      pend_valid_q <= pend_valid_d;
      pend_val_q   <= pend_val_d;
      pend_sm_q    <= pend_sm_d;
      disp_h_q     <= disp_h_d;
      disp_t_q     <= disp_t_d;
      disp_o_q     <= disp_o_d;
      disp_sign_q  <= disp_sign_d;
      refresh_q    <= refresh_d;
      idx_q        <= idx_d;
    end
  end

endmodule

// File: tb/tb_subneg_bcd_display.sv
// tb/tb_subneg_bcd_display.sv - directed self-checking bench for subneg_bcd_display
module tb_subneg_bcd_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] val_in;
  logic       val_we;
  logic       signed_mode;
  logic [6:0] seg, seg_al;
  logic [3:0] dig_sel, dig_sel_al;
  logic       busy, busy_al;

  int n_checks = 0;
  int n_fail   = 0;
  int prev_mag = 0;
  bit prev_neg = 1'b0;

  always #5 clk = ~clk;

  subneg_bcd_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .val_in(val_in), .val_we(val_we), .signed_mode(signed_mode),
    .seg(seg), .dig_sel(dig_sel), .busy(busy)
  );

  subneg_bcd_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .val_in(val_in), .val_we(val_we), .signed_mode(signed_mode),
    .seg(seg_al), .dig_sel(dig_sel_al), .busy(busy_al)
  );

  function automatic logic [6:0] code7(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected active-high segments for a displayed magnitude/sign on digit ds.
  function automatic logic [6:0] model_seg(input int mag, input bit neg, input logic [3:0] ds);
    int h, t, o;
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    case (ds)
      4'b0001: return code7(o);
      4'b0010: return (h == 0 && t == 0) ? 7'h00 : code7(t);
      4'b0100: return (h == 0) ? 7'h00 : code7(h);
      4'b1000: return neg ? 7'h40 : 7'h00;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    val_we = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic strobe(input logic [7:0] v, input logic sm);
    @(negedge clk);
    val_in      = v;
    signed_mode = sm;
    val_we      = 1'b1;
    @(negedge clk);
    val_we = 1'b0;
  endtask

  // Sweeps one full refresh period; got[0..3] from the active-high instance, got[4..7] from the inverted one.
  task automatic scan_digits(output logic [6:0] got [8]);
    for (int b = 0; b < 8; b++) got[b] = 7'bxxxxxxx;
    for (int k = 0; k < 16; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (dig_sel == 4'(1 << b)) got[b] = seg;
        if (~dig_sel_al == 4'(1 << b)) got[4 + b] = ~seg_al;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    val_we = 1'b1;
    val_in = 8'h99;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    val_we = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (dig_sel !== 4'b0001) begin n_fail++; $display("FAIL reset_dig_sel: got %b expected 0001", dig_sel); end
    n_checks++;
    if (seg !== 7'h3F) begin n_fail++; $display("FAIL reset_seg: got %h expected 3f", seg); end
    n_checks++;
    if (dig_sel_al !== 4'b1110) begin n_fail++; $display("FAIL reset_dig_sel_al: got %b expected 1110", dig_sel_al); end
    n_checks++;
    if (seg_al !== 7'h40) begin n_fail++; $display("FAIL reset_seg_al: got %h expected 40", seg_al); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_we_ignored: busy got %b expected 0", busy); end
    prev_mag = 0;
    prev_neg = 1'b0;
  endtask

  task automatic test_refresh();
    logic [3:0] exp_ds;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      exp_ds = 4'(1 << ((k / 4) % 4));
      n_checks++;
      if (dig_sel !== exp_ds) begin n_fail++; $display("FAIL refresh_dig_sel k=%0d: got %b expected %b", k, dig_sel, exp_ds); end
      n_checks++;
      if (dig_sel_al !== ~exp_ds) begin n_fail++; $display("FAIL refresh_dig_sel_al k=%0d: got %b expected %b", k, dig_sel_al, ~exp_ds); end
      n_checks++;
      if (seg !== model_seg(0, 1'b0, exp_ds)) begin n_fail++; $display("FAIL refresh_seg k=%0d: got %h expected %h", k, seg, model_seg(0, 1'b0, exp_ds)); end
      @(negedge clk);
    end
  endtask

  task automatic test_unsigned_255();
    logic [6:0] got [8];
    logic [6:0] exp [4];
    int cnt;
    exp = '{7'h6D, 7'h6D, 7'h5B, 7'h00};
    strobe(8'hFF, 1'b0);
    cnt = 0;
    while (busy && cnt < 40) begin cnt++; @(negedge clk); end
    n_checks++;
    if (cnt !== 9) begin n_fail++; $display("FAIL u255_busy_cycles: got %0d expected 9", cnt); end
    scan_digits(got);
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if (got[b] !== exp[b % 4]) begin n_fail++; $display("FAIL u255 digit%0d: got %h expected %h", b, got[b], exp[b % 4]); end
    end
    prev_mag = 255;
    prev_neg = 1'b0;
  endtask

  task automatic test_signed();
    logic [6:0] got [8];
    logic [6:0] exp [4];
    int cnt;
    exp = '{7'h06, 7'h00, 7'h00, 7'h40};
    strobe(8'hFF, 1'b1);
    cnt = 0;
    while (busy && cnt < 40) begin cnt++; @(negedge clk); end
    n_checks++;
    if (cnt !== 9) begin n_fail++; $display("FAIL sm1_busy_cycles: got %0d expected 9", cnt); end
    scan_digits(got);
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if (got[b] !== exp[b % 4]) begin n_fail++; $display("FAIL minus1 digit%0d: got %h expected %h", b, got[b], exp[b % 4]); end
    end
    exp = '{7'h7F, 7'h5B, 7'h06, 7'h40};
    strobe(8'h80, 1'b1);
    cnt = 0;
    while (busy && cnt < 40) begin cnt++; @(negedge clk); end
    n_checks++;
    if (cnt !== 9) begin n_fail++; $display("FAIL sm128_busy_cycles: got %0d expected 9", cnt); end
    scan_digits(got);
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if (got[b] !== exp[b % 4]) begin n_fail++; $display("FAIL minus128 digit%0d: got %h expected %h", b, got[b], exp[b % 4]); end
    end
    prev_mag = 128;
    prev_neg = 1'b1;
  endtask

  task automatic test_blanking();
    logic [6:0] got [8];
    logic [6:0] exp [4];
    int cnt;
    exp = '{7'h3F, 7'h06, 7'h00, 7'h00};
    strobe(8'h0A, 1'b0);
    cnt = 0;
    while (busy && cnt < 40) begin cnt++; @(negedge clk); end
    n_checks++;
    if (cnt !== 9) begin n_fail++; $display("FAIL ten_busy_cycles: got %0d expected 9", cnt); end
    scan_digits(got);
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if (got[b] !== exp[b % 4]) begin n_fail++; $display("FAIL ten digit%0d: got %h expected %h", b, got[b], exp[b % 4]); end
    end
    exp = '{7'h3F, 7'h00, 7'h00, 7'h00};
    strobe(8'h00, 1'b1);
    cnt = 0;
    while (busy && cnt < 40) begin cnt++; @(negedge clk); end
    n_checks++;
    if (cnt !== 9) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 9", cnt); end
    scan_digits(got);
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if (got[b] !== exp[b % 4]) begin n_fail++; $display("FAIL zero digit%0d: got %h expected %h", b, got[b], exp[b % 4]); end
    end
    prev_mag = 0;
    prev_neg = 1'b0;
  endtask

  // 10 at edge N, 20 at N+2 and 30 at N+4 while converting: 30 wins the buffer.
  task automatic test_pending();
    int mag;
    @(negedge clk);
    val_in = 8'd10; signed_mode = 1'b0; val_we = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      mag = (c < 9) ? prev_mag : (c < 18) ? 10 : 30;
      n_checks++;
      if (busy !== (c <= 17)) begin n_fail++; $display("FAIL pending_busy c=%0d: got %b expected %b", c, busy, (c <= 17)); end
      n_checks++;
      if (seg !== model_seg(mag, (c < 9) ? prev_neg : 1'b0, dig_sel)) begin
        n_fail++; $display("FAIL pending_seg c=%0d dig_sel=%b: got %h expected %h", c, dig_sel, seg, model_seg(mag, (c < 9) ? prev_neg : 1'b0, dig_sel));
      end
      n_checks++;
      if (~seg_al !== model_seg(mag, (c < 9) ? prev_neg : 1'b0, ~dig_sel_al)) begin
        n_fail++; $display("FAIL pending_seg_al c=%0d: got %h expected %h", c, ~seg_al, model_seg(mag, (c < 9) ? prev_neg : 1'b0, ~dig_sel_al));
      end
      val_we = (c == 1 || c == 3);
      val_in = (c == 1) ? 8'd20 : 8'd30;
    end
    val_we = 1'b0;
    prev_mag = 30;
    prev_neg = 1'b0;
  endtask

  // 40 at N, 50 buffered at N+3, 60 on the commit edge N+9: 60 starts directly, 50 is dropped.
  task automatic test_back_to_back();
    int mag;
    @(negedge clk);
    val_in = 8'd40; signed_mode = 1'b0; val_we = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      mag = (c < 9) ? prev_mag : (c < 18) ? 40 : 60;
      n_checks++;
      if (busy !== (c <= 17)) begin n_fail++; $display("FAIL b2b_busy c=%0d: got %b expected %b", c, busy, (c <= 17)); end
      n_checks++;
      if (seg !== model_seg(mag, 1'b0, dig_sel)) begin
        n_fail++; $display("FAIL b2b_seg c=%0d dig_sel=%b: got %h expected %h", c, dig_sel, seg, model_seg(mag, 1'b0, dig_sel));
      end
      val_we = (c == 2 || c == 8);
      val_in = (c == 2) ? 8'd50 : 8'd60;
    end
    val_we = 1'b0;
    prev_mag = 60;
    prev_neg = 1'b0;
  endtask

  // Strobe 200 at N, reset on edge N+4 only; nothing may commit afterwards.
  task automatic test_reset_abort();
    int mag;
    @(negedge clk);
    val_in = 8'd200; signed_mode = 1'b0; val_we = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      mag = (c <= 3) ? prev_mag : 0;
      n_checks++;
      if (busy !== (c <= 3)) begin n_fail++; $display("FAIL abort_busy c=%0d: got %b expected %b", c, busy, (c <= 3)); end
      n_checks++;
      if (seg !== model_seg(mag, 1'b0, dig_sel)) begin
        n_fail++; $display("FAIL abort_seg c=%0d dig_sel=%b: got %h expected %h", c, dig_sel, seg, model_seg(mag, 1'b0, dig_sel));
      end
      if (c == 4) begin
        n_checks++;
        if (dig_sel !== 4'b0001) begin n_fail++; $display("FAIL abort_dig_sel: got %b expected 0001", dig_sel); end
      end
      val_we = 1'b0;
      rst_n  = (c != 3);
    end
    rst_n = 1'b1;
    prev_mag = 0;
    prev_neg = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    val_in      = 8'h00;
    val_we      = 1'b0;
    signed_mode = 1'b0;
    test_reset();
    test_refresh();
    test_unsigned_255();
    test_signed();
    test_blanking();
    test_pending();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
